serial_nibble_receiver: RTL and testbench
=========================================

Name: serial_nibble_receiver

Overview:
- Receive end of the team's serial link; the transmit end is a universal shift register in parallel-load + shift mode.
- Samples a framed serial line on a bit strobe and deserializes WIDTH data bits, LSB-first or MSB-first.
- Presents each good word on a valid/ready holding register.
- Flags framing errors and overruns as sticky status bits.

Parameters:
WIDTH, 4, number of data bits per frame (>=2)

Ports:
CLK  input  1  system clock; all state changes on the rising edge
Clear_b  input  1  asynchronous active-low reset
ser_in  input  1  serial line; idles high
bit_en  input  1  sample strobe; the line is sampled only on cycles with bit_en=1
dir  input  1  0 = LSB-first, 1 = MSB-first; latched at start-bit detection
data_ready  input  1  consumer accepts data_out when high with data_valid
err_clr  input  1  clears frame_err and overrun
data_out  output  WIDTH  holding register contents
data_valid  output  1  holding register is occupied
busy  output  1  high whenever state is not IDLE
frame_err  output  1  sticky: stop bit sampled as 0
overrun  output  1  sticky: good frame arrived while holding register full and not draining

Behaviour:
- Reset is asynchronous and active-low: Clear_b=0 forces the following immediately:
  - state = IDLE; shift register, bit counter and data_out = 0.
  - data_valid, busy, frame_err and overrun = 0.
  - Reset mid-frame aborts the frame; no partial word ever appears.
- Cycles with bit_en=0 leave the FSM, shift register and counter unchanged. Handshake and err_clr are still evaluated every cycle.
- FSM states: IDLE, DATA, [PARITY], STOP.
  - IDLE: bit_en & ser_in=0 -> DATA. Also latch dir and clear bit_cnt. bit_en & ser_in=1 -> stay in IDLE.
  - DATA: each bit_en shifts in ser_in and increments bit_cnt.
    - dir_q=0 (LSB-first): shreg <= {ser_in, shreg[WIDTH-1:1]}.
    - dir_q=1 (MSB-first): shreg <= {shreg[WIDTH-2:0], ser_in}.
    - On the WIDTH-th bit -> STOP, or PARITY when enabled.
  - STOP, on bit_en, always returns to IDLE:
    - ser_in=1 and (data_valid=0 or data_ready=1): data_out <= shreg and data_valid <= 1 on the next edge.
    - ser_in=1, data_valid=1 and data_ready=0: overrun <= 1. The word is dropped and data_out is unchanged.
    - ser_in=0: frame_err <= 1 and the word is dropped.
- A start bit is accepted on the bit_en immediately after STOP; there are no idle bits between frames.
- Handshake:
  - data_valid & data_ready at a rising edge consumes the word; data_valid falls unless the same edge loads a new word.
  - data_out stays stable while data_valid=1 and data_ready=0.
- Latency: data_valid rises on the edge that samples the stop bit. It is visible the cycle after that bit_en cycle.
- err_clr=1 clears both sticky flags. A new error on the same edge wins and the flag stays 1.
- bit_cnt width is clog2(WIDTH)+1. The counter never wraps within a frame.

Optional Feature:
Macro: SNR_PARITY_EN
- Defined:
  - A PARITY state follows DATA and consumes one extra bit_en sample, expected to give even parity over the data bits plus the parity bit.
  - A mismatch sets output parity_err (sticky, cleared by err_clr, error wins) and the word is discarded at STOP.
  - parity_err resets to 0.
- Undefined:
  - No PARITY state and no parity_err port; the frame is start + WIDTH data + stop.

Test Plan:
- Reset, then bit_en pulsed every 4 cycles with ser_in held 1 for 10 strobes -> busy=0, data_valid=0, all flags 0.
- dir=0, data_ready=0, frame 0,1,0,1,1,1 (start, b0..b3, stop) -> data_out=4'b1101 and data_valid=1 one cycle after the stop strobe; stays until data_ready=1 for one cycle, then data_valid=0.
- dir=1, same serial bits -> data_out=4'b1011. Toggling dir mid-frame has no effect on the result.
- Back-to-back good frames 0x3 then 0xA, with data_ready=0 throughout -> data_out stays 0x3 and overrun=1. Repeat with data_ready=1 on the second stop edge -> data_out=0xA, data_valid remains 1, overrun=0.
- Frame with stop bit 0 -> frame_err=1 and data_valid unchanged. err_clr=1 for one cycle -> frame_err=0. The next good frame 0x5 is received correctly.
- Clear_b pulsed low after 2 data bits -> all outputs 0 immediately. The next full frame 0xC is received with no corruption. With SNR_PARITY_EN, data 0x7 with parity bit 0 -> parity_err=1 and no data_valid.

Source files
------------

// File: rtl/serial_nibble_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits (LSB- or MSB-first), stop bit.
// Optional even-parity bit between data and stop when SNR_PARITY_EN is defined.
module serial_nibble_receiver #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             ser_in,
    input  logic             bit_en,
    input  logic             dir,
    input  logic             data_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
`ifdef SNR_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic              dir_q;
    logic [WIDTH-1:0]  data_out_q;
    logic              data_valid_q;
    logic              frame_err_q;
    logic              overrun_q;

    logic start_hit, shift_en, stop_hit, last_bit, good_stop;
    logic load_word, overrun_set, frame_err_set;

`ifdef SNR_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;
    logic parity_set;

    assign parity_set = bit_en && (state_q == StParity) && ((^shreg_q) ^ ser_in);
    assign good_stop  = ser_in && !par_bad_q;
`else
    assign good_stop  = ser_in;
`endif

    assign start_hit     = bit_en && (state_q == StIdle) && !ser_in;
    assign shift_en      = bit_en && (state_q == StData);
    assign stop_hit      = bit_en && (state_q == StStop);
    assign last_bit      = (bit_cnt_q == CntW'(WIDTH - 1));
    assign load_word     = stop_hit && good_stop && (!data_valid_q || data_ready);
    assign overrun_set   = stop_hit && good_stop && data_valid_q && !data_ready;
    assign frame_err_set = stop_hit && !ser_in;

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            case (state_q)
                StIdle:   if (!ser_in) state_d = StData;
`ifdef SNR_PARITY_EN
                StData:   if (last_bit) state_d = StParity;
`else
                StData:   if (last_bit) state_d = StStop;
`endif
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            dir_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (start_hit) begin
                dir_q     <= dir;
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
                if (dir_q) shreg_q <= {shreg_q[WIDTH-2:0], ser_in};
                else       shreg_q <= {ser_in, shreg_q[WIDTH-1:1]};
            end
            // A load on the consuming edge keeps the holding register full.
            if (load_word) begin
                data_out_q   <= shreg_q;
                data_valid_q <= 1'b1;
            end else if (data_valid_q && data_ready) begin
                data_valid_q <= 1'b0;
            end
            frame_err_q <= frame_err_set || (frame_err_q && !err_clr);
            overrun_q   <= overrun_set || (overrun_q && !err_clr);
        end
    end

`ifdef SNR_PARITY_EN
    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (start_hit)       par_bad_q <= 1'b0;
            else if (parity_set) par_bad_q <= 1'b1;
            parity_err_q <= parity_set || (parity_err_q && !err_clr);
        end
    end
`endif

    always_comb begin
        busy       = (state_q != StIdle);
        data_out   = data_out_q;
        data_valid = data_valid_q;
        frame_err  = frame_err_q;
        overrun    = overrun_q;
`ifdef SNR_PARITY_EN
        parity_err = parity_err_q;
`endif
    end

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Directed bench for serial_nibble_receiver (default build, WIDTH=4).
module tb_serial_nibble_receiver;

    logic       CLK = 1'b0;
    logic       Clear_b;
    logic       ser_in;
    logic       bit_en;
    logic       dir;
    logic       data_ready;
    logic       err_clr;
    logic [3:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    serial_nibble_receiver #(.WIDTH(4)) dut (
        .CLK        (CLK),
        .Clear_b    (Clear_b),
        .ser_in     (ser_in),
        .bit_en     (bit_en),
        .dir        (dir),
        .data_ready (data_ready),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Three idle cycles, then one strobe cycle; returns half a cycle after the sampling edge.
    task automatic strobe(input logic b, input logic r, input logic c);
        repeat (3) @(negedge CLK);
        ser_in     = b;
        bit_en     = 1'b1;
        data_ready = r;
        err_clr    = c;
        @(negedge CLK);
        bit_en     = 1'b0;
        data_ready = 1'b0;
        err_clr    = 1'b0;
        ser_in     = 1'b1;
    endtask

    // seq[0] is sent first.
    task automatic send_frame(input logic [3:0] seq, input logic stop);
        strobe(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) strobe(seq[i], 1'b0, 1'b0);
        strobe(stop, 1'b0, 1'b0);
    endtask

    task automatic consume();
        @(negedge CLK);
        data_ready = 1'b1;
        @(negedge CLK);
        data_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
    endtask

    initial begin
        Clear_b    = 1'b0;
        ser_in     = 1'b1;
        bit_en     = 1'b0;
        dir        = 1'b0;
        data_ready = 1'b0;
        err_clr    = 1'b0;
        #2;
        check("rst_data_out", data_out, 4'h0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        repeat (2) @(negedge CLK);
        Clear_b = 1'b1;

        // Idle line must not start a frame
        for (int i = 0; i < 10; i++) strobe(1'b1, 1'b0, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_valid", data_valid, 1'b0);
        check("idle_ferr", frame_err, 1'b0);
        check("idle_ovr", overrun, 1'b0);

        // LSB-first: bits 1,0,1,1 -> 4'b1101
        strobe(1'b0, 1'b0, 1'b0);
        check("lsb_busy_after_start", busy, 1'b1);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        check("lsb_valid_before_stop", data_valid, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        check("lsb_valid", data_valid, 1'b1);
        check("lsb_data", data_out, 4'b1101);
        check("lsb_busy_after_stop", busy, 1'b0);
        repeat (3) @(negedge CLK);
        check("lsb_hold_valid", data_valid, 1'b1);
        check("lsb_hold_data", data_out, 4'b1101);
        consume();
        check("lsb_consumed", data_valid, 1'b0);

        // MSB-first, same serial bits -> 4'b1011
        dir = 1'b1;
        send_frame(4'b1101, 1'b1);
        check("msb_valid", data_valid, 1'b1);
        check("msb_data", data_out, 4'b1011);
        consume();

        // dir toggled after start bit is ignored
        dir = 1'b1;
        strobe(1'b0, 1'b0, 1'b0);
        dir = 1'b0;
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        check("dir_toggle_data", data_out, 4'b1011);
        consume();

        // Overrun: 0x3 then 0xA without draining
        send_frame(4'h3, 1'b1);
        check("b2b_first", data_out, 4'h3);
        send_frame(4'hA, 1'b1);
        check("ovr_data_kept", data_out, 4'h3);
        check("ovr_valid", data_valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        pulse_clr();
        check("ovr_cleared", overrun, 1'b0);
        consume();
        check("ovr_consumed", data_valid, 1'b0);

        // Drain on the same edge as the second stop: new word replaces old
        send_frame(4'h3, 1'b1);
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b1, 1'b0);
        check("drain_data", data_out, 4'hA);
        check("drain_valid", data_valid, 1'b1);
        check("drain_ovr", overrun, 1'b0);
        consume();

        // Framing error
        send_frame(4'h6, 1'b0);
        check("ferr_flag", frame_err, 1'b1);
        check("ferr_valid", data_valid, 1'b0);
        check("ferr_data", data_out, 4'hA);
        pulse_clr();
        check("ferr_cleared", frame_err, 1'b0);
        send_frame(4'h5, 1'b1);
        check("after_ferr_data", data_out, 4'h5);
        check("after_ferr_valid", data_valid, 1'b1);
        check("after_ferr_flag", frame_err, 1'b0);
        consume();

        // New error on the err_clr edge wins
        strobe(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b1);
        check("ferr_wins_clr", frame_err, 1'b1);
        pulse_clr();
        check("ferr_wins_then_clr", frame_err, 1'b0);

        // Asynchronous reset mid-frame
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        check("mid_busy", busy, 1'b1);
        @(negedge CLK);
        Clear_b = 1'b0;
        #1;
        check("mid_rst_data", data_out, 4'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", data_valid, 1'b0);
        @(negedge CLK);
        Clear_b = 1'b1;
        send_frame(4'hC, 1'b1);
        check("post_rst_data", data_out, 4'hC);
        check("post_rst_valid", data_valid, 1'b1);
        consume();
        check("post_rst_consumed", data_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
